// File: rtl/max7219_rx_decoder.sv
// max7219_rx_decoder: receive end of a MAX7219 daisy chain; deserializes LOAD/DIN/CLK
// and commits each 16-bit word into a per-matrix register image with frame checking.
module max7219_rx_decoder #(
    parameter int G_NB_MATRIX = 8,
    parameter int G_BIT_CNT_W = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_max7219_clk,
    input  logic                   i_max7219_din,
    input  logic                   i_max7219_load,
    input  logic [3:0]             i_rd_matrix,
    input  logic [3:0]             i_rd_addr,
    output logic [7:0]             o_rd_data,
    output logic                   o_busy,
    output logic                   o_frame_done,
    output logic                   o_frame_err,
    output logic [G_BIT_CNT_W-1:0] o_bit_cnt
);
    localparam int L_SR_W = 16 * G_NB_MATRIX;
    localparam logic [G_BIT_CNT_W-1:0] L_FULL = G_BIT_CNT_W'(L_SR_W);
    localparam logic [3:0] L_LAST = 4'(G_NB_MATRIX - 1);
    localparam logic [4:0] L_NB = 5'(G_NB_MATRIX);

    typedef enum logic [1:0] {S_IDLE, S_COMMIT, S_DONE} t_state;
    t_state r_state, w_state_next;

    logic [2:0]             r_sclk_sync, r_load_sync;
    logic [1:0]             r_din_sync;
    logic [L_SR_W-1:0]      r_sr, r_snap, w_sr_next;
    logic [G_BIT_CNT_W-1:0] r_bit_cnt, w_cnt_next;
    logic [3:0]             r_m;
    logic                   r_busy, r_done, r_err, r_cap_err, r_missed;
    logic [7:0]             r_rd_data;
    logic [7:0]             r_image [16][16];
    logic                   w_sclk_rise, w_load_rise, w_start, w_wr_en;
    logic [3:0]             w_addr;
    logic [7:0]             w_data, w_wr_data;

    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_load_rise = r_load_sync[1] & ~r_load_sync[2];
    assign w_start     = w_load_rise && r_state == S_IDLE;
    // a CLK rise coinciding with the LOAD rise still belongs to the closing frame
    assign w_sr_next   = w_sclk_rise ? {r_sr[L_SR_W-2:0], r_din_sync[1]} : r_sr;
    assign w_cnt_next  = (w_sclk_rise && !(&r_bit_cnt)) ? r_bit_cnt + 1'b1 : r_bit_cnt;
    assign w_addr      = r_snap[11:8];
    assign w_data      = r_snap[7:0];

    always_comb begin
        w_state_next = (r_state == S_IDLE)   ? (w_load_rise ? S_COMMIT : S_IDLE) :
                       (r_state == S_COMMIT) ? (r_m == L_LAST ? S_DONE : S_COMMIT) : S_IDLE;
        w_wr_en      = r_state == S_COMMIT && w_addr != 4'h0 && w_addr != 4'hD && w_addr != 4'hE;
        w_wr_data    = (w_addr == 4'hA) ? {4'h0, w_data[3:0]} :
                       (w_addr == 4'hB) ? {5'h0, w_data[2:0]} :
                       (w_addr == 4'hC || w_addr == 4'hF) ? {7'h0, w_data[0]} : w_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sclk_sync <= '0;
            r_load_sync <= '0;
            r_din_sync  <= '0;
            r_sr        <= '0;
            r_snap      <= '0;
            r_bit_cnt   <= '0;
            r_m         <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cap_err   <= 1'b0;
            r_missed    <= 1'b0;
            r_rd_data   <= '0;
            for (int i = 0; i < 16; i++)
                for (int j = 0; j < 16; j++)
                    r_image[i][j] <= '0;
        end else begin
            r_state     <= w_state_next;
            r_sclk_sync <= {r_sclk_sync[1:0], i_max7219_clk};
            r_load_sync <= {r_load_sync[1:0], i_max7219_load};
            r_din_sync  <= {r_din_sync[0], i_max7219_din};
            r_sr        <= w_sr_next;
            r_bit_cnt   <= w_start ? '0 : w_cnt_next;
            // rotate by one word so the current matrix always sits in the low 16 bits
            r_snap      <= w_start ? w_sr_next :
                           (r_state == S_COMMIT) ? L_SR_W'({r_snap, r_snap} >> 16) : r_snap;
            r_m         <= (r_state == S_COMMIT) ? r_m + 4'd1 : '0;
            r_cap_err   <= w_start ? (w_cnt_next != L_FULL) || r_missed : r_cap_err;
            r_missed    <= w_start ? 1'b0 : (w_load_rise && r_state != S_IDLE) ? 1'b1 : r_missed;
            r_done      <= r_state == S_DONE;
            r_err       <= r_state == S_DONE && r_cap_err;
            r_busy      <= w_start || (r_busy && !r_done);
            if (w_wr_en)
                r_image[r_m][w_addr] <= w_wr_data;
            r_rd_data   <= ({1'b0, i_rd_matrix} < L_NB) ? r_image[i_rd_matrix][i_rd_addr] : 8'h00;
        end
    end

    assign o_rd_data    = r_rd_data;
    assign o_busy       = r_busy;
    assign o_frame_done = r_done;
    assign o_frame_err  = r_err;
    assign o_bit_cnt    = r_bit_cnt;
endmodule

// File: tb/tb_max7219_rx_decoder.sv
// tb_max7219_rx_decoder: drives serial MAX7219 frames and compares the register image,
// frame flags and bit count against a word-level reference model.
module tb_max7219_rx_decoder;
    localparam int N = 8;

    logic        clk = 0, rst_n = 0, sclk = 0, din = 0, load = 0;
    logic [3:0]  rd_m = 0, rd_a = 0;
    logic [7:0]  rd_data;
    logic        busy, done, err;
    logic [11:0] bit_cnt;

    int checks = 0, errors = 0;

    logic [16*N-1:0] m_sr;
    int              m_cnt;
    bit              m_missed;
    logic [7:0]      m_img [16][16];

    max7219_rx_decoder #(.G_NB_MATRIX(N), .G_BIT_CNT_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .i_max7219_clk(sclk), .i_max7219_din(din),
        .i_max7219_load(load), .i_rd_matrix(rd_m), .i_rd_addr(rd_a), .o_rd_data(rd_data),
        .o_busy(busy), .o_frame_done(done), .o_frame_err(err), .o_bit_cnt(bit_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic model_reset();
        m_sr = '0;
        m_cnt = 0;
        m_missed = 0;
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                m_img[i][j] = 8'h00;
    endtask

    function automatic bit model_commit();
        bit e = (m_cnt != 16 * N) || m_missed;
        m_missed = 0;
        m_cnt = 0;
        for (int m = 0; m < N; m++) begin
            logic [15:0] w = m_sr[16*m +: 16];
            case (w[11:8])
                4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9: m_img[m][w[11:8]] = w[7:0];
                4'hA: m_img[m][10] = w[7:0] & 8'h0F;
                4'hB: m_img[m][11] = w[7:0] & 8'h07;
                4'hC: m_img[m][12] = w[7:0] & 8'h01;
                4'hF: m_img[m][15] = w[7:0] & 8'h01;
                default: ;
            endcase
        end
        return e;
    endfunction

    task automatic send_bit(input bit b);
        @(negedge clk) din = b;
        repeat (4) @(negedge clk);
        sclk = 1;
        repeat (4) @(negedge clk);
        sclk = 0;
        m_sr = {m_sr[16*N-2:0], b};
        if (m_cnt < 4095) m_cnt++;
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic send_all(input logic [15:0] w);
        for (int m = 0; m < N; m++) send_word(w);
    endtask

    // load pulse; optional second pulse lands while the first frame is committing
    task automatic do_commit(input bit extra, output int lat, output bit e, output bit busy_after);
        @(negedge clk) load = 1;
        lat = 0;
        while (lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 4) load = 0;
            if (extra && lat == 6) load = 1;
            if (extra && lat == 10) load = 0;
            if (done) break;
        end
        e = err;
        @(negedge clk);
        busy_after = busy;
        load = 0;
    endtask

    task automatic read_reg(input int m, input int a, output logic [7:0] d);
        @(negedge clk);
        rd_m = 4'(m);
        rd_a = 4'(a);
        @(negedge clk);
        d = rd_data;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || bit_cnt !== 12'd0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b err=%b cnt=%0d, want all 0", busy, done, err, bit_cnt);
        end
        for (int m = 0; m < 16; m++)
            for (int a = 0; a < 16; a++) begin
                read_reg(m, a, d);
                checks++;
                if (d !== 8'h00) begin
                    errors++;
                    $display("FAIL reset_image m%0d a%0h: got %h want 00", m, a, d);
                end
            end
    endtask

    task automatic test_shutdown();
        int lat; bit e, ba, ee; logic [7:0] d;
        send_all(16'h0C01);
        checks++;
        if (bit_cnt !== 12'(16 * N)) begin
            errors++;
            $display("FAIL shutdown_bitcnt: got %0d want %0d", bit_cnt, 16 * N);
        end
        ee = model_commit();
        do_commit(0, lat, e, ba);
        checks++;
        if (lat !== 12 || e !== ee || ba !== 1'b0) begin
            errors++;
            $display("FAIL shutdown_commit: lat=%0d err=%b busy_after=%b, want 12 %b 0", lat, e, ee, ba);
        end
        for (int m = 0; m < 16; m++)
            for (int a = 0; a < 16; a++) begin
                read_reg(m, a, d);
                checks++;
                if (d !== m_img[m][a] || (m < N && a == 12 && d !== 8'h01)) begin
                    errors++;
                    $display("FAIL shutdown_image m%0d a%0h: got %h want %h", m, a, d, m_img[m][a]);
                end
            end
    endtask

    task automatic test_digits();
        int lat; bit e, ba, ee; logic [7:0] d;
        send_word(16'h08AA);
        for (int m = N - 2; m >= 1; m--) send_word(16'h0000);
        send_word(16'h0155);
        ee = model_commit();
        do_commit(0, lat, e, ba);
        checks++;
        if (lat !== 12 || e !== ee) begin
            errors++;
            $display("FAIL digits_commit: lat=%0d err=%b, want 12 %b", lat, e, ee);
        end
        for (int m = 0; m < 16; m++)
            for (int a = 0; a < 16; a++) begin
                read_reg(m, a, d);
                checks++;
                if (d !== m_img[m][a]) begin
                    errors++;
                    $display("FAIL digits_image m%0d a%0h: got %h want %h", m, a, d, m_img[m][a]);
                end
            end
    endtask

    task automatic test_partial();
        int lat; bit e, ba, ee; logic [7:0] d;
        for (int i = 0; i < 48; i++) send_bit(1'($urandom));
        checks++;
        if (bit_cnt !== 12'd48) begin
            errors++;
            $display("FAIL partial_bitcnt: got %0d want 48", bit_cnt);
        end
        ee = model_commit();
        do_commit(0, lat, e, ba);
        checks++;
        if (lat !== 12 || e !== 1'b1 || ee !== 1'b1 || bit_cnt !== 12'd0) begin
            errors++;
            $display("FAIL partial_commit: lat=%0d err=%b cnt=%0d, want 12 1 0", lat, e, bit_cnt);
        end
        for (int m = 0; m < 16; m++)
            for (int a = 0; a < 16; a++) begin
                read_reg(m, a, d);
                checks++;
                if (d !== m_img[m][a]) begin
                    errors++;
                    $display("FAIL partial_image m%0d a%0h: got %h want %h", m, a, d, m_img[m][a]);
                end
            end
    endtask

    task automatic test_masks();
        logic [15:0] words [3] = '{16'h0AFF, 16'h0BFF, 16'h0D12};
        int lat; bit e, ba, ee; logic [7:0] d;
        for (int k = 0; k < 3; k++) begin
            send_all(words[k]);
            ee = model_commit();
            do_commit(0, lat, e, ba);
            checks++;
            if (lat !== 12 || e !== ee) begin
                errors++;
                $display("FAIL masks_commit %h: lat=%0d err=%b, want 12 %b", words[k], lat, e, ee);
            end
            for (int m = 0; m < 16; m++)
                for (int a = 0; a < 16; a++) begin
                    read_reg(m, a, d);
                    checks++;
                    if (d !== m_img[m][a]) begin
                        errors++;
                        $display("FAIL masks_image %h m%0d a%0h: got %h want %h", words[k], m, a, d, m_img[m][a]);
                    end
                end
        end
    endtask

    task automatic test_back_to_back();
        int lat; bit e, ba, ee; logic [7:0] d;
        send_all(16'h0377);
        ee = model_commit();
        do_commit(1, lat, e, ba);
        m_missed = 1;
        checks++;
        if (lat !== 12 || e !== ee || bit_cnt !== 12'd0) begin
            errors++;
            $display("FAIL b2b_first: lat=%0d err=%b cnt=%0d, want 12 %b 0", lat, e, bit_cnt, ee);
        end
        send_all(16'h0466);
        ee = model_commit();
        do_commit(0, lat, e, ba);
        checks++;
        if (lat !== 12 || e !== 1'b1 || ee !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: lat=%0d err=%b, want 12 1", lat, e);
        end
        for (int m = 0; m < 16; m++)
            for (int a = 0; a < 16; a++) begin
                read_reg(m, a, d);
                checks++;
                if (d !== m_img[m][a]) begin
                    errors++;
                    $display("FAIL b2b_image m%0d a%0h: got %h want %h", m, a, d, m_img[m][a]);
                end
            end
    endtask

    task automatic test_random();
        int lat, nb; bit e, ba, ee; logic [7:0] d;
        for (int k = 0; k < 4; k++) begin
            nb = (k % 2 == 0) ? 16 * N : int'($urandom_range(1, 200));
            for (int i = 0; i < nb; i++) send_bit(1'($urandom));
            checks++;
            if (bit_cnt !== 12'(nb)) begin
                errors++;
                $display("FAIL random_bitcnt %0d: got %0d want %0d", k, bit_cnt, nb);
            end
            ee = model_commit();
            do_commit(0, lat, e, ba);
            checks++;
            if (lat !== 12 || e !== ee || ba !== 1'b0) begin
                errors++;
                $display("FAIL random_commit %0d: lat=%0d err=%b busy_after=%b, want 12 %b 0", k, lat, e, ba, ee);
            end
            for (int m = 0; m < 16; m++)
                for (int a = 0; a < 16; a++) begin
                    read_reg(m, a, d);
                    checks++;
                    if (d !== m_img[m][a]) begin
                        errors++;
                        $display("FAIL random_image %0d m%0d a%0h: got %h want %h", k, m, a, d, m_img[m][a]);
                    end
                end
        end
    endtask

    task automatic test_reset_mid_commit();
        int lat; bit e, ba, ee; logic [7:0] d;
        for (int m = 0; m < N; m++) send_word({8'(m % 8 + 1), 8'($urandom)});
        @(negedge clk) load = 1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 4) load = 0;
        end
        rst_n = 0;
        #1;
        model_reset();
        checks++;
        if (busy !== 1'b0 || bit_cnt !== 12'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: busy=%b cnt=%0d done=%b, want 0 0 0", busy, bit_cnt, done);
        end
        @(negedge clk) rst_n = 1;
        for (int m = 0; m < 16; m++)
            for (int a = 0; a < 16; a++) begin
                read_reg(m, a, d);
                checks++;
                if (d !== 8'h00) begin
                    errors++;
                    $display("FAIL midreset_image m%0d a%0h: got %h want 00", m, a, d);
                end
            end
        for (int m = 0; m < N; m++) send_word({8'(m % 8 + 1), 8'($urandom)});
        ee = model_commit();
        do_commit(0, lat, e, ba);
        checks++;
        if (lat !== 12 || e !== 1'b0 || ee !== 1'b0) begin
            errors++;
            $display("FAIL midreset_clean: lat=%0d err=%b, want 12 0", lat, e);
        end
        for (int m = 0; m < 16; m++)
            for (int a = 0; a < 16; a++) begin
                read_reg(m, a, d);
                checks++;
                if (d !== m_img[m][a]) begin
                    errors++;
                    $display("FAIL midreset_after m%0d a%0h: got %h want %h", m, a, d, m_img[m][a]);
                end
            end
    endtask

    initial begin
        test_reset();
        test_shutdown();
        test_digits();
        test_partial();
        test_masks();
        test_back_to_back();
        test_random();
        test_reset_mid_commit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
